echo_result_framer: RTL and testbench
=====================================

# echo_result_framer

Packs each echo measurement result (time-of-flight and correlation peak) into a fixed 10-byte frame and streams it one byte at a time to the byte-wide serial transmitter. It sits directly downstream of the echo correlation stage and upstream of the UART byte transmitter, which reaches the TBS link. It decouples the one-cycle `processing_done` pulse from the slow serial drain. It provides a one-result pending buffer, a frame sequence number, checksum protection and a drop counter.

## Interface
Parameters:
- `HDR0`, default 8'hAA, first header byte
- `HDR1`, default 8'h55, second header byte

Ports:
- `clk_50M`  in  1  system clock; the block uses only this clock
- `rst`  in  1  synchronous, active-high reset
- `echo_tof`  in  20  time-of-flight result; sampled only when `processing_done`=1
- `echo_peak`  in  18  correlation peak; sampled only when `processing_done`=1
- `processing_done`  in  1  single-cycle result strobe
- `tx_data`  out  8  byte offered to the transmitter
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  transmitter accepts the byte on this edge
- `frame_busy`  out  1  a frame is in progress or a result is pending
- `drop_cnt`  out  8  count of results lost to overflow; saturates at 255

## Operation
- Frame bytes, by index:
  - 0: `HDR0`
  - 1: `HDR1`
  - 2: SEQ
  - 3: {4'b0, tof[19:16]}
  - 4: tof[15:8]
  - 5: tof[7:0]
  - 6: {6'b0, peak[17:16]}
  - 7: peak[15:8]
  - 8: peak[7:0]
  - 9: CHK
- CHK is the mod-256 sum of bytes 2..8, unless the configuration macro changes it (see Configuration).
- Storage:
  - Active register: tof, peak, seq.
  - Pending slot: tof, peak, and a valid flag.
- States:
  - IDLE: `tx_valid`=0.
  - SEND: `tx_valid`=1 and `tx_data` = byte[idx], with idx 0..9.
- IDLE + `processing_done`: capture the inputs into the active register and go to SEND with idx=0.
- SEND: a byte transfers on each edge where `tx_valid`&&`tx_ready`; idx then increments.
- When byte 9 transfers:
  - If the pending slot is valid: pending moves to active, seq increments, and the state stays SEND with idx=0 (zero-gap).
  - Otherwise, if `processing_done` is 1 on the same cycle: the new result moves to active and the state stays SEND with idx=0.
  - Otherwise: go to IDLE.
- `processing_done` during SEND, when not consumed by the byte-9 rule above:
  - Pending empty: capture into pending.
  - Pending full: discard the result and increment `drop_cnt` (saturating). The pending contents are unchanged.
- Byte 9 transfers, pending full and `processing_done`=1 on the same cycle: pending moves to active, the new result moves to pending, and nothing is dropped.
- SEQ:
  - The first frame after reset carries 0.
  - SEQ increments by 1 for each frame started and wraps 255→0.
  - SEQ is latched with the active register, so it is stable across the whole frame.
- `frame_busy` = (state==SEND) | pending valid.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=8'h00, `frame_busy`=0, `drop_cnt`=0; SEQ counter=0; pending slot invalid; state IDLE.
- Reset mid-frame: the frame is abandoned and `tx_valid` is 0 in the cycle after `rst` is sampled; the pending result is discarded.
- Latency: `processing_done` sampled in IDLE at edge N puts `tx_valid`=1 with `tx_data`=`HDR0` after edge N (one cycle).
- Handshake: while `tx_valid`=1 && `tx_ready`=0, `tx_data` and `tx_valid` hold. `tx_valid` never drops mid-frame.
- With `tx_ready` held at 1, a frame occupies exactly 10 cycles; back-to-back frames have no idle cycle.
- Inputs `echo_tof` and `echo_peak` are ignored in cycles without `processing_done`.

## Configuration
- `ECHO_FRAMER_CRC8_EN` defined: CHK = CRC-8 over bytes 2..8.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR, MSB first.
  - Computed incrementally, one byte per transfer, with no added latency.
- Macro undefined: CHK = mod-256 sum of bytes 2..8. No CRC logic is present.

## Test plan
- Basic frame: from reset, `echo_tof`=20'h12345, `echo_peak`=18'h2ABCD, `tx_ready`=1 → bytes AA 55 00 01 23 45 02 AB CD E3 on 10 consecutive cycles, then `tx_valid`=0. With CRC enabled, CHK must match the CRC-8 model.
- Backpressure: same stimulus with `tx_ready` toggling 1,0,0,1… → identical byte sequence, and `tx_data` stable during every stall.
- Pending/zero-gap: second strobe at byte index 4 → the second frame starts the cycle after byte 9 with SEQ=01.
- Overflow: three strobes during one frame with `tx_ready`=0 → only the first and second results are framed, and `drop_cnt`=1. Driving 300 excess strobes → `drop_cnt` saturates at 255.
- Simultaneous: strobe on the cycle byte 9 transfers with pending full → pending and the new result are both sent in order, and `drop_cnt` is unchanged.
- Reset mid-frame at byte 5 → `tx_valid`=0 the next cycle; the next frame carries SEQ=00 and `drop_cnt`=0.

Source files
------------

// File: rtl/echo_result_framer.sv
// Packs echo results (tof, peak) into 10-byte frames streamed over a byte handshake.
// Define ECHO_FRAMER_CRC8_EN to use a CRC-8 check byte instead of the mod-256 sum.
module echo_result_framer #(
  parameter logic [7:0] HDR0 = 8'hAA,
  parameter logic [7:0] HDR1 = 8'h55
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic [19:0] echo_tof,
  input  logic [17:0] echo_peak,
  input  logic        processing_done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_busy,
  output logic [7:0]  drop_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state;
  logic [3:0]  idx;
  logic [19:0] act_tof;
  logic [17:0] act_peak;
  logic [7:0]  act_seq;
  logic [7:0]  seq_cnt;
  logic [7:0]  chk_acc;
  logic [19:0] pend_tof;
  logic [17:0] pend_peak;
  logic        pend_valid;

  logic [7:0]  cur_byte;
  logic        take;
  logic        last;
  logic        start;
  logic        start_from_pend;

`ifdef ECHO_FRAMER_CRC8_EN
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
    logic [7:0] c;
    c = acc ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`else
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  always_comb begin
    cur_byte = '0;
    case (idx)
      4'd0: cur_byte = HDR0;
      4'd1: cur_byte = HDR1;
      4'd2: cur_byte = act_seq;
      4'd3: cur_byte = {4'b0, act_tof[19:16]};
      4'd4: cur_byte = act_tof[15:8];
      4'd5: cur_byte = act_tof[7:0];
      4'd6: cur_byte = {6'b0, act_peak[17:16]};
      4'd7: cur_byte = act_peak[15:8];
      4'd8: cur_byte = act_peak[7:0];
      4'd9: cur_byte = chk_acc;
      default: cur_byte = '0;
    endcase
  end

  assign tx_valid   = (state == SEND);
  assign tx_data    = tx_valid ? cur_byte : '0;
  assign frame_busy = tx_valid | pend_valid;

  // A new frame starts either from IDLE or directly after byte 9 (zero-gap);
  // the pending slot always has priority over a same-cycle strobe.
  always_comb begin
    take            = tx_valid && tx_ready;
    last            = take && (idx == 4'd9);
    start_from_pend = (state == SEND) && pend_valid;
    start           = ((state == IDLE) && processing_done) ||
                      (last && (pend_valid || processing_done));
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      act_tof    <= '0;
      act_peak   <= '0;
      act_seq    <= '0;
      seq_cnt    <= '0;
      chk_acc    <= '0;
      pend_tof   <= '0;
      pend_peak  <= '0;
      pend_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (start) begin
        act_tof  <= start_from_pend ? pend_tof  : echo_tof;
        act_peak <= start_from_pend ? pend_peak : echo_peak;
        act_seq  <= seq_cnt;
        seq_cnt  <= seq_cnt + 8'd1;
        idx      <= '0;
        chk_acc  <= '0;
        state    <= SEND;
      end else if (last) begin
        idx   <= '0;
        state <= IDLE;
      end else if (take) begin
        idx <= idx + 4'd1;
        if (idx >= 4'd2 && idx <= 4'd8)
          chk_acc <= chk_step(chk_acc, cur_byte);
      end

      // Pending slot: refilled when it drains on byte 9, otherwise fill-or-drop
      if (state == SEND) begin
        if (last) begin
          if (pend_valid && processing_done) begin
            pend_tof  <= echo_tof;
            pend_peak <= echo_peak;
          end else if (pend_valid) begin
            pend_valid <= 1'b0;
          end
        end else if (processing_done) begin
          if (!pend_valid) begin
            pend_tof   <= echo_tof;
            pend_peak  <= echo_peak;
            pend_valid <= 1'b1;
          end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_result_framer.sv
// Self-checking bench for echo_result_framer: byte-stream queue model plus directed
// scenarios and randomized traffic. Honors ECHO_FRAMER_CRC8_EN for the check byte.
module tb_echo_result_framer;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic [19:0] echo_tof;
  logic [17:0] echo_peak;
  logic        processing_done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_busy;
  logic [7:0]  drop_cnt;

  always #5 clk_50M = ~clk_50M;

  echo_result_framer #(.HDR0(8'hAA), .HDR1(8'h55)) dut (
    .clk_50M(clk_50M),
    .rst(rst),
    .echo_tof(echo_tof),
    .echo_peak(echo_peak),
    .processing_done(processing_done),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .frame_busy(frame_busy),
    .drop_cnt(drop_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          armed    = 1'b0;

  logic [7:0] exp_q[$];   // every byte still owed to the transmitter
  logic [7:0] obs[$];     // bytes actually handed over by the DUT
  logic [7:0] m_seq;
  logic [7:0] m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8_step(input logic [7:0] acc, input logic [7:0] b);
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  function automatic logic [9:0][7:0] make_frame(input logic [19:0] tof, input logic [17:0] peak,
                                                 input logic [7:0] seq);
    logic [9:0][7:0] f;
    logic [7:0] c;
    f[0] = 8'hAA;
    f[1] = 8'h55;
    f[2] = seq;
    f[3] = {4'b0, tof[19:16]};
    f[4] = tof[15:8];
    f[5] = tof[7:0];
    f[6] = {6'b0, peak[17:16]};
    f[7] = peak[15:8];
    f[8] = peak[7:0];
    c = 8'h00;
    for (int i = 2; i <= 8; i++) begin
`ifdef ECHO_FRAMER_CRC8_EN
      c = crc8_step(c, f[i]);
`else
      c = c + f[i];
`endif
    end
    f[9] = c;
    return f;
  endfunction

  // Model: a result is accepted if, after this edge's transfer, at most one frame's worth remains owed.
  initial begin
    logic [9:0][7:0] f;
    forever begin
      @(posedge clk_50M);
      if (rst === 1'b1) begin
        exp_q.delete();
        m_seq  = 8'h00;
        m_drop = 8'h00;
      end else if (armed) begin
        if (exp_q.size() != 0 && tx_ready) void'(exp_q.pop_front());
        if (processing_done) begin
          if (exp_q.size() <= 10) begin
            f = make_frame(echo_tof, echo_peak, m_seq);
            for (int i = 0; i < 10; i++) exp_q.push_back(f[i]);
            m_seq = m_seq + 8'd1;
          end else if (m_drop != 8'hFF) begin
            m_drop = m_drop + 8'd1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_50M);
      if (armed) begin
        check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
        check("frame_busy", {31'b0, frame_busy}, {31'b0, exp_q.size() != 0});
        check("drop_cnt", {24'b0, drop_cnt}, {24'b0, m_drop});
        if (exp_q.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, exp_q[0]});
        if (tx_valid === 1'b1 && tx_ready === 1'b1) obs.push_back(tx_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_50M);
    #2;
  endtask

  task automatic strobe(input logic [19:0] tof, input logic [17:0] peak);
    processing_done = 1'b1;
    echo_tof        = tof;
    echo_peak       = peak;
    tick();
    processing_done = 1'b0;
    echo_tof        = 20'($urandom);
    echo_peak       = 18'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs.delete();
  endtask

  initial begin
    logic [7:0] basic [10];
    logic [9:0][7:0] pf;
    logic [7:0] acc;
    logic [7:0] chk_str [9];

    basic = '{8'hAA, 8'h55, 8'h00, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'hE3};
    chk_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst = 1'b1; processing_done = 1'b0; tx_ready = 1'b0;
    echo_tof = '0; echo_peak = '0;
    repeat (3) tick();
    armed = 1'b1;
    tick();
    rst = 1'b0;

    check("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("reset_tx_data", {24'b0, tx_data}, 32'h00);
    check("reset_frame_busy", {31'b0, frame_busy}, 32'd0);
    check("reset_drop_cnt", {24'b0, drop_cnt}, 32'd0);

    // Pin the model to hand-computed values
    pf = make_frame(20'h12345, 18'h2ABCD, 8'h00);
    for (int i = 0; i < 9; i++) check("model_frame_byte", {24'b0, pf[i]}, {24'b0, basic[i]});
`ifdef ECHO_FRAMER_CRC8_EN
    acc = 8'h00;
    for (int i = 0; i < 9; i++) acc = crc8_step(acc, chk_str[i]);
    check("model_crc8_check", {24'b0, acc}, 32'hF4);
`else
    acc = 8'h00;
    check("model_sum_chk", {24'b0, pf[9]}, 32'hE3);
`endif

    // Basic frame
    tx_ready = 1'b1;
    strobe(20'h12345, 18'h2ABCD);
    repeat (11) tick();
    check("basic_len", obs.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
`ifdef ECHO_FRAMER_CRC8_EN
      if (i == 9) check("basic_byte", {24'b0, obs[i]}, {24'b0, pf[9]});
      else check("basic_byte", {24'b0, obs[i]}, {24'b0, basic[i]});
`else
      check("basic_byte", {24'b0, obs[i]}, {24'b0, basic[i]});
`endif
    end

    // Backpressure
    do_reset();
    tx_ready = 1'b1;
    strobe(20'h12345, 18'h2ABCD);
    for (int k = 1; k <= 40; k++) begin
      tx_ready = (k % 3 == 0);
      tick();
    end
    check("bp_len", obs.size(), 32'd10);
    for (int i = 0; i < 9; i++) check("bp_byte", {24'b0, obs[i]}, {24'b0, basic[i]});
    check("bp_chk", {24'b0, obs[9]}, {24'b0, pf[9]});

    // Pending / zero-gap
    do_reset();
    tx_ready = 1'b1;
    strobe(20'hABCDE, 18'h01234);
    repeat (4) tick();
    strobe(20'h00F0F, 18'h3FFFF);
    repeat (20) tick();
    check("zg_len", obs.size(), 32'd20);
    check("zg_seq0", {24'b0, obs[2]}, 32'h00);
    check("zg_hdr", {24'b0, obs[10]}, 32'hAA);
    check("zg_seq1", {24'b0, obs[12]}, 32'h01);

    // Overflow and saturation
    do_reset();
    tx_ready = 1'b0;
    strobe(20'h11111, 18'h11111);
    strobe(20'h22222, 18'h22222);
    strobe(20'h33333, 18'h33333);
    check("ovf_drop1", {24'b0, drop_cnt}, 32'd1);
    tx_ready = 1'b1;
    repeat (25) tick();
    check("ovf_len", obs.size(), 32'd20);
    check("ovf_tof2", {24'b0, obs[15]}, 32'h22);
    tx_ready = 1'b0;
    for (int i = 0; i < 302; i++) strobe(20'($urandom), 18'($urandom));
    check("ovf_sat", {24'b0, drop_cnt}, 32'd255);
    tx_ready = 1'b1;
    repeat (25) tick();

    // Strobe on byte 9 with pending full
    do_reset();
    tx_ready = 1'b1;
    strobe(20'h0000A, 18'h0000A);
    repeat (2) tick();
    strobe(20'h0000B, 18'h0000B);
    repeat (6) tick();
    strobe(20'h0000C, 18'h0000C);
    repeat (35) tick();
    check("sim_len", obs.size(), 32'd30);
    check("sim_drop", {24'b0, drop_cnt}, 32'd0);
    check("sim_seq1", {24'b0, obs[12]}, 32'h01);
    check("sim_seq2", {24'b0, obs[22]}, 32'h02);
    check("sim_tof_c", {24'b0, obs[25]}, 32'h0C);

    // Reset mid-frame
    do_reset();
    tx_ready = 1'b1;
    strobe(20'h12345, 18'h2ABCD);
    strobe(20'h54321, 18'h1DCBA);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", {31'b0, tx_valid}, 32'd0);
    check("midrst_busy", {31'b0, frame_busy}, 32'd0);
    obs.delete();
    strobe(20'h12345, 18'h2ABCD);
    repeat (12) tick();
    check("midrst_len", obs.size(), 32'd10);
    check("midrst_seq", {24'b0, obs[2]}, 32'h00);
    check("midrst_drop", {24'b0, drop_cnt}, 32'd0);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      rst             = ($urandom_range(0, 799) == 0);
      processing_done = ($urandom_range(0, 5) == 0);
      tx_ready        = ($urandom_range(0, 3) != 0);
      echo_tof        = 20'($urandom);
      echo_peak       = 18'($urandom);
      tick();
    end
    rst = 1'b0; processing_done = 1'b0; tx_ready = 1'b1;
    repeat (30) tick();
    check("final_idle", {31'b0, tx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
